// File: rtl/regwb_ctrl.sv
// Register-file write-side controller: merges in-order pipe writebacks with buffered
// long-latency results on one write port and tracks pending writes for ID-stage stalls.
module regwb_ctrl #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_we,
   input  logic [AW-1:0] pipe_waddr,
   input  logic [DW-1:0] pipe_wdata,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_waddr,
   output logic          issue_ready,
   input  logic          lr_valid,
   input  logic [AW-1:0] lr_waddr,
   input  logic [DW-1:0] lr_wdata,
   output logic          lr_ready,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   input  logic          qre1,
   input  logic [AW-1:0] qaddr1,
   input  logic          qre2,
   input  logic [AW-1:0] qaddr2,
   output logic          qbusy1,
   output logic          qbusy2,
   output logic          stall_req,
   output logic          err
);
   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned PW   = $clog2(DEPTH);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } lr_entry_t;

   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_nxt;
   lr_entry_t       fifo_mem [DEPTH];
   logic [PW:0]     wr_ptr;
   logic [PW:0]     rd_ptr;
   lr_entry_t       head;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fifo_pop;
   logic            lr_push;
   logic            issue_fire;
   logic            pipe_sel;
   logic            err_set;

   // FIFO status; pointers carry one extra wrap bit to tell full from empty
   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      head       = fifo_mem[rd_ptr[PW-1:0]];
   end

   // Handshakes and arbitration decision: pipe has priority, r0 pipe writes yield
   always_comb begin
      pipe_sel    = pipe_we && (pipe_waddr != '0);
      fifo_pop    = !rst && !pipe_sel && !fifo_empty;
      issue_ready = !rst && !sb[issue_waddr];
      lr_ready    = !rst && !fifo_full;
      issue_fire  = issue_valid && issue_ready;
      lr_push     = lr_valid && lr_ready;
   end

   // Write port; an r0 FIFO head is drained with we low
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (!rst) begin
         if (pipe_sel) begin
            we    = 1'b1;
            waddr = pipe_waddr;
            wdata = pipe_wdata;
         end else if (!fifo_empty) begin
            we    = (head.addr != '0);
            waddr = head.addr;
            wdata = head.data;
         end
      end
   end

   // Queries see the same-cycle drain as not busy since the regfile bypasses wdata
   always_comb begin
      qbusy1    = !rst && sb[qaddr1] && !(fifo_pop && (head.addr == qaddr1));
      qbusy2    = !rst && sb[qaddr2] && !(fifo_pop && (head.addr == qaddr2));
      stall_req = (qre1 && qbusy1) || (qre2 && qbusy2);
   end

   // Scoreboard next state and protocol checks
   always_comb begin
      sb_nxt = sb;
      if (fifo_pop && (head.addr != '0)) sb_nxt[head.addr] = 1'b0;
      if (issue_fire && (issue_waddr != '0)) sb_nxt[issue_waddr] = 1'b1;
      err_set = (pipe_sel && sb[pipe_waddr]) ||
                (lr_push && (lr_waddr != '0) && !sb[lr_waddr]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb     <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         err    <= 1'b0;
      end else begin
         sb <= sb_nxt;
         if (lr_push)  wr_ptr <= wr_ptr + (PW+1)'(1);
         if (fifo_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
         if (err_set)  err <= 1'b1;
      end
   end

   // Payload storage needs no reset: entries are only read between push and pop
   always_ff @(posedge clk) begin
      if (lr_push) fifo_mem[wr_ptr[PW-1:0]] <= '{addr: lr_waddr, data: lr_wdata};
   end

endmodule

// File: doc/regwb_ctrl.md
# regwb_ctrl

Write-side controller for the 32x32 general register file. It sits between the MEM/WB pipeline register and a long-latency result source (divider, cache-miss load) on one side, and the register file's single write port (`we`/`waddr`/`wdata`) on the other. It buffers out-of-order long-latency results and arbitrates them onto the write port. It also keeps a per-register pending-write scoreboard, which the ID stage queries to stall on operands that are not yet written.

## Interface
- `DW`, 32: data width.
- `AW`, 5: register address width (32 registers).
- `DEPTH`, 2: long-latency result FIFO depth (power of 2, ≥2).

Reset is `rst`, synchronous, active-high. The clock is `clk`.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `pipe_we`  in  1  in-order writeback request from MEM/WB.
- `pipe_waddr`  in  AW  writeback destination.
- `pipe_wdata`  in  DW  writeback data.
- `issue_valid`  in  1  a long-latency op is issued with destination `issue_waddr`.
- `issue_waddr`  in  AW  destination of the issued op.
- `issue_ready`  out  1  issue accepted when `issue_valid && issue_ready`.
- `lr_valid`  in  1  long-latency result available.
- `lr_waddr`  in  AW  result destination.
- `lr_wdata`  in  DW  result data.
- `lr_ready`  out  1  result accepted when `lr_valid && lr_ready`.
- `we`, `waddr`, `wdata`  out  1/AW/DW  to the register file write port.
- `qre1`, `qaddr1`, `qre2`, `qaddr2`  in  1/AW  ID-stage operand queries.
- `qbusy1`, `qbusy2`  out  1  queried register has a pending long-latency write.
- `stall_req`  out  1  `(qre1 && qbusy1) || (qre2 && qbusy2)`.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- **Scoreboard** `sb[31:0]`, registered.
  - An issue handshake with `issue_waddr != 0` sets `sb[issue_waddr]`.
  - An issue with address 0 is accepted and sets nothing.
  - `issue_ready = !rst && !sb[issue_waddr]`: at most one outstanding write per register.
- **Result FIFO**, DEPTH entries of {addr, data}.
  - `lr_ready = !rst && !full`.
  - There is no push/pop pass-through when full.
- **Write-port arbitration**, combinational, pipeline first:
  - If `pipe_we && pipe_waddr != 0`, drive the pipe triple onto the port.
  - Otherwise, if the FIFO is non-empty, drive the FIFO head with `we = (head.addr != 0)` and pop the head at the edge. A head with address 0 is discarded.
  - Otherwise `we = 0`, `waddr = 0`, `wdata = 0`.
- **Scoreboard clear**: when the FIFO head is popped with addr ≠ 0, clear `sb[head.addr]` at that edge.
- **Same-register set and clear in one cycle**: cannot occur, because `issue_ready` is low while the bit is set.
- **Query**:
  - `qbusyN = sb[qaddrN] && !(fifo_pop && head.addr == qaddrN)`.
  - This is valid because the register file bypasses `wdata` to same-cycle reads.
  - `qaddrN == 0` always gives `qbusyN = 0`.
- **Error conditions**, each sets `err` at the next edge; `err` stays high until reset:
  - a pipe write to a register whose `sb` bit is set (WAW; the write is still performed);
  - an `lr` result whose address ≠ 0 and whose `sb` bit is clear at acceptance.
- **Reset**: `sb = 0`, FIFO empty, `err = 0`. While `rst` is high, `we`, `issue_ready`, `lr_ready`, `qbusy*` and `stall_req` are all 0. Any in-flight FIFO contents are discarded.

## Timing
- Pipe write: zero latency, combinational from `pipe_*` to `we`/`waddr`/`wdata`.
- Long-latency result:
  - accepted at edge N;
  - earliest drive on the port is cycle N+1, and only if `pipe_we` is low or targets r0;
  - the `sb` bit clears at the edge ending that cycle.
- Sustained `pipe_we` starves the FIFO. `lr_ready` falls once DEPTH results are held and rises in the cycle after a pop.
- Issue handshake at edge N: `qbusy` is high from cycle N+1.
- All registered state updates on the `clk` rising edge only.

## Test plan
1. **Reset**: assert `rst` mid-operation with 2 FIFO entries and `sb[5]` set. The next cycle shows `we = 0`, `lr_ready = 0`, `issue_ready = 0`. After `rst` falls: `sb = 0`, FIFO empty, `err = 0`.
2. **Basic long-latency path**:
   - issue r7 → `qaddr1 = 7`, `qre1 = 1` gives `stall_req = 1`;
   - `lr_valid` r7 = `0xDEADBEEF` → next cycle `we = 1`, `waddr = 7`, `wdata = 0xDEADBEEF`, `qbusy1 = 0` in that same cycle;
   - the following cycle has `sb[7] = 0`.
3. **Arbitration**: hold `pipe_we = 1` (r3, `0x11`) for 4 cycles while pushing results r8 and r9.
   - The port shows r3 for all 4 cycles.
   - `lr_ready = 0` after the second push.
   - r8 then r9 drain on the next 2 cycles, in order.
4. **r0 handling**:
   - issue r0 → accepted, `sb` unchanged;
   - `lr` r0 → popped with `we = 0`;
   - `pipe_we` r0 plus a FIFO entry → the FIFO entry is written in that cycle.
5. **Errors**: with `sb[4]` set, `pipe_we` r4 → the write occurs and `err = 1` next cycle. Separately, an `lr` r6 with `sb[6] = 0` also raises `err`.
6. **Issue back-pressure**: with `sb[10]` set, issue r10 → `issue_ready = 0` until the cycle after r10 is written, then 1.
